// File: rtl/selector_pkg.sv
// Package: selector_pkg
// Purpose: shared types and width helpers for the nibble selector datapath.
//   src_idx_w / nib_idx_w : index widths derived from the block parameters
//                           (never narrower than 1 bit)
//   lane_sel_t            : per-lane (source, nibble) selection, fixed-width fields
//   sel_state_e           : storage occupancy of the output/skid pair
package selector_pkg;

  localparam int IDX_FIELD_W = 8;

  function automatic int src_idx_w(input int num_src);
    return (num_src > 2) ? $clog2(num_src) : 1;
  endfunction

  function automatic int nib_idx_w(input int data_w, input int nib_w);
    int nibs;
    nibs = data_w / nib_w;
    return (nibs > 2) ? $clog2(nibs) : 1;
  endfunction

  typedef struct packed {
    logic [IDX_FIELD_W-1:0] src;
    logic [IDX_FIELD_W-1:0] nib;
  } lane_sel_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } sel_state_e;

endpackage

// File: rtl/sel_skid_buf.sv
// Module: sel_skid_buf
// Purpose: generic 2-entry valid/ready skid buffer. Full throughput, with a
//   registered IN_READY that never depends combinationally on OUT_READY.
// Ports:
//   CLK, RESET          clock, synchronous active-high reset
//   IN_VALID/IN_READY   upstream handshake, IN_DATA [W] payload
//   OUT_VALID/OUT_READY downstream handshake, OUT_DATA [W] payload
//
// state | meaning
// ------+-----------------------------------------------
// EMPTY | output stage invalid, skid empty
// ONE   | output stage valid, skid empty
// FULL  | output stage and skid both valid, IN_READY low
module sel_skid_buf
  import selector_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [W-1:0] IN_DATA,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [W-1:0] OUT_DATA
);

  sel_state_e   state, state_nxt;
  logic         in_ready_q;
  logic [W-1:0] skid_data;
  logic         in_fire, out_fire;
  logic         load_out_from_in, load_out_from_skid, load_skid;

  // Gating with RESET keeps both handshakes dead during the reset cycle.
  assign IN_READY  = in_ready_q & ~RESET;
  assign OUT_VALID = (state != EMPTY) & ~RESET;
  assign in_fire   = IN_VALID & IN_READY;
  assign out_fire  = OUT_VALID & OUT_READY;

  always_comb begin
    state_nxt          = state;
    load_out_from_in   = 1'b0;
    load_out_from_skid = 1'b0;
    load_skid          = 1'b0;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          load_out_from_in = 1'b1;
          state_nxt        = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          load_out_from_in = 1'b1;
        end else if (in_fire) begin
          load_skid = 1'b1;
          state_nxt = FULL;
        end else if (out_fire) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          load_out_from_skid = 1'b1;
          state_nxt          = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
      OUT_DATA   <= '0;
      skid_data  <= '0;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != FULL);
      if (load_out_from_in) begin
        OUT_DATA <= IN_DATA;
      end else if (load_out_from_skid) begin
        OUT_DATA <= skid_data;
      end
      if (load_skid) begin
        skid_data <= IN_DATA;
      end
    end
  end

endmodule

// File: rtl/nibble_selector_pipe.sv
// Module: nibble_selector_pipe
// Purpose: pipelined nibble selector. Each of LANES output nibbles is taken
//   from DATA[SEL_SRC[l]] at nibble position SEL_NIB[l], captured on accept and
//   delivered through a 2-entry skid buffer. A source index >= NUM_SRC yields 0.
// Ports:
//   CLK, RESET            clock, synchronous active-high reset
//   IN_VALID, IN_READY    input handshake
//   DATA                  [NUM_SRC][DATA_W] source words
//   SEL_SRC, SEL_NIB      per-lane source / nibble index
//   OUT_VALID, OUT_READY  output handshake
//   NIBBLE_OUT            [LANES][NIB_W] selected nibbles
//   XFER_COUNT            completed output handshakes, wrapping
//   OUT_PARITY            [LANES] per-lane XOR parity (only with SEL_PARITY_EN)
// Build option: define SEL_PARITY_EN to add OUT_PARITY.
module nibble_selector_pipe
  import selector_pkg::*;
#(
  parameter  int NUM_SRC   = 2,
  parameter  int DATA_W    = 32,
  parameter  int NIB_W     = 4,
  parameter  int LANES     = 4,
  parameter  int CNT_W     = 16,
  localparam int SRC_IDX_W = src_idx_w(NUM_SRC),
  localparam int NIB_IDX_W = nib_idx_w(DATA_W, NIB_W)
) (
  input  logic                                CLK,
  input  logic                                RESET,
  input  logic                                IN_VALID,
  output logic                                IN_READY,
  input  logic [NUM_SRC-1:0][DATA_W-1:0]      DATA,
  input  logic [LANES-1:0][SRC_IDX_W-1:0]     SEL_SRC,
  input  logic [LANES-1:0][NIB_IDX_W-1:0]     SEL_NIB,
  output logic                                OUT_VALID,
  input  logic                                OUT_READY,
  output logic [LANES-1:0][NIB_W-1:0]         NIBBLE_OUT,
  output logic [CNT_W-1:0]                    XFER_COUNT
`ifdef SEL_PARITY_EN
  ,
  output logic [LANES-1:0]                    OUT_PARITY
`endif
);

  localparam int NIBS  = DATA_W / NIB_W;
  localparam int NIB_BITS = LANES * NIB_W;
`ifdef SEL_PARITY_EN
  localparam int PAY_W = NIB_BITS + LANES;
`else
  localparam int PAY_W = NIB_BITS;
`endif

  lane_sel_t [LANES-1:0]           lane_sel;
  logic      [LANES-1:0][NIB_W-1:0] lane_nib;
  logic      [PAY_W-1:0]           in_payload;
  logic      [PAY_W-1:0]           out_payload;

  // Compare-and-select instead of direct indexing so an out-of-range source
  // index simply matches nothing and leaves the lane at zero.
  always_comb begin
    lane_sel = '0;
    lane_nib = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_sel[l].src = IDX_FIELD_W'(SEL_SRC[l]);
      lane_sel[l].nib = IDX_FIELD_W'(SEL_NIB[l]);
      for (int s = 0; s < NUM_SRC; s++) begin
        for (int n = 0; n < NIBS; n++) begin
          if (int'(lane_sel[l].src) == s && int'(lane_sel[l].nib) == n) begin
            lane_nib[l] = DATA[s][n*NIB_W +: NIB_W];
          end
        end
      end
    end
  end

`ifdef SEL_PARITY_EN
  logic [LANES-1:0] lane_par;

  always_comb begin
    lane_par = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_par[l] = ^lane_nib[l];
    end
  end

  // Parity rides in the payload so it stays aligned with its beat.
  assign in_payload = {lane_par, lane_nib};
  assign OUT_PARITY = out_payload[PAY_W-1 -: LANES];
`else
  assign in_payload = lane_nib;
`endif

  sel_skid_buf #(
    .W (PAY_W)
  ) u_skid (
    .CLK       (CLK),
    .RESET     (RESET),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_DATA   (in_payload),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_DATA  (out_payload)
  );

  assign NIBBLE_OUT = out_payload[NIB_BITS-1:0];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      XFER_COUNT <= '0;
    end else if (OUT_VALID && OUT_READY) begin
      XFER_COUNT <= XFER_COUNT + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_nibble_selector_pipe.sv
// Testbench for nibble_selector_pipe (three sources so that an out-of-range
// source index is reachable). Parity is checked when SEL_PARITY_EN is defined.
module tb_nibble_selector_pipe;

  logic                 CLK;
  logic                 RESET;
  logic                 IN_VALID;
  logic                 IN_READY;
  logic [2:0][31:0]     DATA;
  logic [3:0][1:0]      SEL_SRC;
  logic [3:0][2:0]      SEL_NIB;
  logic                 OUT_VALID;
  logic                 OUT_READY;
  logic [3:0][3:0]      NIBBLE_OUT;
  logic [15:0]          XFER_COUNT;
`ifdef SEL_PARITY_EN
  logic [3:0]           OUT_PARITY;
`endif

  int n_checks = 0;
  int n_errors = 0;

  nibble_selector_pipe #(
    .NUM_SRC (3),
    .DATA_W  (32),
    .NIB_W   (4),
    .LANES   (4),
    .CNT_W   (16)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .IN_VALID   (IN_VALID),
    .IN_READY   (IN_READY),
    .DATA       (DATA),
    .SEL_SRC    (SEL_SRC),
    .SEL_NIB    (SEL_NIB),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY),
    .NIBBLE_OUT (NIBBLE_OUT),
    .XFER_COUNT (XFER_COUNT)
`ifdef SEL_PARITY_EN
    ,
    .OUT_PARITY (OUT_PARITY)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Reference selection: {parity, nibbles}; parity field is 0 without the option.
  function automatic logic [19:0] model(input logic [2:0][31:0] d,
                                        input logic [3:0][1:0]  s,
                                        input logic [3:0][2:0]  n);
    logic [15:0] nib;
    logic [3:0]  par;
    nib = '0;
    par = '0;
    for (int l = 0; l < 4; l++) begin
      if (s[l] < 2'd3) nib[l*4 +: 4] = d[s[l]][int'(n[l])*4 +: 4];
`ifdef SEL_PARITY_EN
      par[l] = ^nib[l*4 +: 4];
`endif
    end
    return {par, nib};
  endfunction

  function automatic logic [19:0] observed();
`ifdef SEL_PARITY_EN
    return {OUT_PARITY, NIBBLE_OUT};
`else
    return {4'h0, NIBBLE_OUT};
`endif
  endfunction

  logic [19:0] q[$];
  logic [19:0] held;
  logic        stalled_prev;
  int          accepted;
  int          emitted;
  int          guard;

  initial begin
    RESET     = 1'b1;
    IN_VALID  = 1'b0;
    OUT_READY = 1'b0;
    DATA      = '0;
    SEL_SRC   = '0;
    SEL_NIB   = '0;
    step();
    step();
    chk("rst_in_ready_hi", 32'(IN_READY), 32'd0);
    chk("rst_out_valid_hi", 32'(OUT_VALID), 32'd0);
    RESET = 1'b0;
    #1;
    chk("rst_in_ready", 32'(IN_READY), 32'd1);
    chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
    chk("rst_nibble", 32'(NIBBLE_OUT), 32'h0);
    chk("rst_count", 32'(XFER_COUNT), 32'd0);

    // Basic selection from source 1, nibble positions 3..0.
    DATA[0]   = 32'h00000FFF;
    DATA[1]   = 32'h0000ABCD;
    DATA[2]   = 32'h12345678;
    SEL_SRC   = {2'd1, 2'd1, 2'd1, 2'd1};
    SEL_NIB   = {3'd3, 3'd2, 3'd1, 3'd0};
    IN_VALID  = 1'b1;
    OUT_READY = 1'b1;
    step();
    chk("t1_valid", 32'(OUT_VALID), 32'd1);
    chk("t1_nibble", 32'(NIBBLE_OUT), 32'hABCD);
    chk("t1_count", 32'(XFER_COUNT), 32'd0);

    // Mixed sources; DATA[1] nibble 3 is A.
    SEL_SRC = {2'd0, 2'd0, 2'd1, 2'd1};
    SEL_NIB = {3'd0, 3'd3, 3'd0, 3'd3};
    step();
    chk("t2_nibble", 32'(NIBBLE_OUT), 32'hF0DA);
    chk("t2_count", 32'(XFER_COUNT), 32'd1);
`ifdef SEL_PARITY_EN
    chk("t2_parity", 32'(OUT_PARITY), 32'b0010);
`endif

    // Source index 3 does not exist and must give zero.
    SEL_SRC = {2'd3, 2'd2, 2'd3, 2'd2};
    SEL_NIB = {3'd0, 3'd7, 3'd1, 3'd1};
    step();
    chk("t2b_nibble", 32'(NIBBLE_OUT), 32'h0107);
    chk("t2b_count", 32'(XFER_COUNT), 32'd2);
    IN_VALID = 1'b0;
    step();
    chk("t2b_drain_valid", 32'(OUT_VALID), 32'd0);
    chk("t2b_drain_count", 32'(XFER_COUNT), 32'd3);

    // Backpressure: two beats fit, third waits.
    SEL_SRC   = {2'd1, 2'd1, 2'd1, 2'd1};
    SEL_NIB   = {3'd3, 3'd2, 3'd1, 3'd0};
    OUT_READY = 1'b0;
    IN_VALID  = 1'b1;
    DATA[1]   = 32'h1111;
    step();
    chk("t3_ready_after1", 32'(IN_READY), 32'd1);
    chk("t3_out1", 32'(NIBBLE_OUT), 32'h1111);
    DATA[1] = 32'h2222;
    step();
    chk("t3_ready_full", 32'(IN_READY), 32'd0);
    chk("t3_out_hold1", 32'(NIBBLE_OUT), 32'h1111);
    DATA[1] = 32'h3333;
    step();
    chk("t3_ready_full2", 32'(IN_READY), 32'd0);
    chk("t3_out_hold2", 32'(NIBBLE_OUT), 32'h1111);
    chk("t3_valid_hold", 32'(OUT_VALID), 32'd1);
    OUT_READY = 1'b1;
    step();
    chk("t3_out2", 32'(NIBBLE_OUT), 32'h2222);
    chk("t3_ready_free", 32'(IN_READY), 32'd1);
    step();
    chk("t3_out3", 32'(NIBBLE_OUT), 32'h3333);
    IN_VALID = 1'b0;
    step();
    chk("t3_drain_valid", 32'(OUT_VALID), 32'd0);
    chk("t3_count", 32'(XFER_COUNT), 32'd6);

    // Reset while FULL discards everything.
    OUT_READY = 1'b0;
    IN_VALID  = 1'b1;
    DATA[1]   = 32'h4444;
    step();
    DATA[1] = 32'h5555;
    step();
    chk("t6_full", 32'(IN_READY), 32'd0);
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    RESET     = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(OUT_VALID), 32'd0);
    chk("t6_rst_ready", 32'(IN_READY), 32'd0);
    step();
    RESET = 1'b0;
    #1;
    chk("t6_ready_after", 32'(IN_READY), 32'd1);
    chk("t6_valid_after", 32'(OUT_VALID), 32'd0);
    chk("t6_count_after", 32'(XFER_COUNT), 32'd0);
    chk("t6_nibble_after", 32'(NIBBLE_OUT), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_no_stale", 32'(OUT_VALID), 32'd0);
    end

    // Random stream against a scoreboard, with random backpressure.
    accepted     = 0;
    emitted      = 0;
    guard        = 0;
    stalled_prev = 1'b0;
    held         = '0;
    while (!(accepted == 100 && q.size() == 0 && !OUT_VALID) && guard < 3000) begin
      guard++;
      IN_VALID  = (accepted < 100) ? ($urandom_range(0, 3) != 0) : 1'b0;
      OUT_READY = 1'($urandom_range(0, 1));
      for (int s = 0; s < 3; s++) DATA[s] = $urandom;
      for (int l = 0; l < 4; l++) begin
        SEL_SRC[l] = 2'($urandom_range(0, 3));
        SEL_NIB[l] = 3'($urandom_range(0, 7));
      end
      #1;
      if (stalled_prev) begin
        chk("t4_stall_valid", 32'(OUT_VALID), 32'd1);
        chk("t4_stall_data", 32'(observed()), 32'(held));
      end
      if (IN_VALID && IN_READY) begin
        q.push_back(model(DATA, SEL_SRC, SEL_NIB));
        accepted++;
      end
      if (OUT_VALID && OUT_READY) begin
        if (q.size() == 0) begin
          chk("t4_spurious_beat", 32'd1, 32'd0);
        end else begin
          chk("t4_beat", 32'(observed()), 32'(q.pop_front()));
        end
        emitted++;
      end
      stalled_prev = OUT_VALID && !OUT_READY;
      held         = observed();
      step();
    end
    chk("t4_accepted", 32'(accepted), 32'd100);
    chk("t4_emitted", 32'(emitted), 32'd100);
    chk("t4_count", 32'(XFER_COUNT), 32'(emitted));

    // Counter wrap.
    IN_VALID  = 1'b1;
    OUT_READY = 1'b1;
    guard     = 0;
    while (XFER_COUNT != 16'hFFFE && guard < 70000) begin
      guard++;
      step();
    end
    chk("t5_pre", 32'(XFER_COUNT), 32'h0000FFFE);
    step();
    chk("t5_ffff", 32'(XFER_COUNT), 32'h0000FFFF);
    step();
    chk("t5_wrap", 32'(XFER_COUNT), 32'h00000000);
    IN_VALID = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
